// File: rtl/ratio_cos_pipe.sv
// Pipelined y = sign * (a/(a+d)) * (b*|cos c|) with serial d reload and stall-all flow control.
// Define RATIO_COS_ROUND_EN for a round-half-up final shift; truncation otherwise.
module ratio_cos_pipe #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d_valid,
  input  logic         d_bit,
  output logic         d_done,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] cosv,
  input  logic         cos_sign,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   y
);

  localparam int unsigned CW = $clog2(W);
  localparam int unsigned NDIV = W + 1;
  localparam logic [W-1:0] MAG_MAX = '1;

  // rem/q evolve through the divider; s and bc ride along unchanged
  typedef struct packed {
    logic         vld;
    logic         sgn;
    logic [W:0]   s;
    logic [W-1:0] bc;
    logic [W:0]   rem;
    logic [W:0]   q;
  } div_t;

  logic en;
  logic accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Serial d loader, independent of the datapath stalls
  logic [W-1:0]  d_shadow;
  logic [W-1:0]  d_act;
  logic [CW-1:0] d_cnt;
  logic          d_commit_c;

  assign d_commit_c = d_valid && (d_cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_shadow <= '0;
      d_act    <= '0;
      d_cnt    <= '0;
      d_done   <= 1'b0;
    end else begin
      d_done <= d_commit_c;
      if (d_valid) begin
        d_shadow <= {d_shadow[W-2:0], d_bit};
        d_cnt    <= d_commit_c ? '0 : d_cnt + CW'(1);
        if (d_commit_c) d_act <= {d_shadow[W-2:0], d_bit};
      end
    end
  end

  // Front stage: sum, truncated b*cosv, divider seed
  logic [2*W-1:0] bprod_c;
  div_t           s0_c;

  assign bprod_c = (2*W)'(b) * (2*W)'(cosv);

  always_comb begin
    s0_c     = '0;
    s0_c.vld = accept;
    s0_c.sgn = cos_sign;
    s0_c.s   = (W+1)'(a) + (W+1)'(d_act);
    s0_c.bc  = bprod_c[2*W-1:W];
    s0_c.rem = (W+1)'(a);
  end

  // One restoring step; the first step yields the integer quotient bit (set only when a >= s)
  function automatic div_t div_step(input div_t x, input logic first);
    div_t         r;
    logic [W+1:0] r2;
    logic [W+1:0] dv;
    r  = x;
    dv = (W+2)'(x.s);
    r2 = first ? (W+2)'(x.rem) : {x.rem, 1'b0};
    if (r2 >= dv) begin
      r2  = r2 - dv;
      r.q = {x.q[W-1:0], 1'b1};
    end else begin
      r.q = {x.q[W-1:0], 1'b0};
    end
    r.rem = r2[W:0];
    return r;
  endfunction

  div_t s0_r;
  div_t div_r [NDIV];

  // Quotient saturation: integer bit set means q = 2^W (d = 0), or s = 0 which forces 0
  logic [W-1:0] q_c;

  always_comb begin
    q_c = div_r[W].q[W-1:0];
    if (div_r[W].q[W]) q_c = (div_r[W].s == '0) ? '0 : MAG_MAX;
  end

  logic           prod_vld;
  logic           prod_sgn;
  logic [2*W-1:0] prod_r;
  logic [W-1:0]   mag_c;
  logic           unused_ok_c;

`ifdef RATIO_COS_ROUND_EN
  logic [2*W:0] rsum_c;

  assign rsum_c = (2*W+1)'(prod_r) + ((2*W+1)'(1) << (W - 1));
  assign mag_c  = (rsum_c[2*W:W] > (W+1)'(MAG_MAX)) ? MAG_MAX : rsum_c[2*W-1:W];
  assign unused_ok_c = ^{bprod_c[W-1:0], div_r[W].rem, rsum_c[W-1:0]};
`else
  assign mag_c = prod_r[2*W-1:W];
  assign unused_ok_c = ^{bprod_c[W-1:0], div_r[W].rem, prod_r[W-1:0]};
`endif

  logic         sh_vld;
  logic         sh_sgn;
  logic [W-1:0] sh_mag;

  // Stall-all pipeline: every rank advances together on en, bubbles included
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_r <= '0;
      for (int j = 0; j < NDIV; j++) div_r[j] <= '0;
      prod_vld  <= 1'b0;
      prod_sgn  <= 1'b0;
      prod_r    <= '0;
      sh_vld    <= 1'b0;
      sh_sgn    <= 1'b0;
      sh_mag    <= '0;
      out_valid <= 1'b0;
      y         <= '0;
    end else if (en) begin
      s0_r     <= s0_c;
      div_r[0] <= div_step(s0_r, 1'b1);
      for (int j = 1; j < NDIV; j++) div_r[j] <= div_step(div_r[j-1], 1'b0);
      prod_vld  <= div_r[W].vld;
      prod_sgn  <= div_r[W].sgn;
      prod_r    <= (2*W)'(q_c) * (2*W)'(div_r[W].bc);
      sh_vld    <= prod_vld;
      sh_sgn    <= prod_sgn;
      sh_mag    <= mag_c;
      out_valid <= sh_vld;
      y         <= sh_vld ? {sh_sgn && (sh_mag != '0), sh_mag} : '0;
    end
  end

endmodule
